key_debouncer: RTL and testbench
================================

# key_debouncer

Debounces and synchronises the board pushbuttons (active-low `KEY[1:0]`) into clean, active-high levels and single-cycle press/release pulses. It sits directly upstream of the 32-bit counter register in the `Pratica02` top level. `press_pulse_o` is the step/enable source that replaces the free-running `+1` on every clock. There is one independent channel per key, all in the 50 MHz `FPGA_CLK1_50` domain.

## Interface

Parameters:
- `N_KEYS`, default 2: number of independent key channels.
- `STABLE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz). Legal range is ≥ 1.
- `CNT_WIDTH`, derived local parameter: `$clog2(STABLE_CYCLES+1)`. Not overridable.

Ports:
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `reset_n` input, 1 bit: reset, asynchronous, active-low.
- `key_n_i` input, `N_KEYS` bits: raw asynchronous keys, 0 = pressed.
- `pressed_o` output, `N_KEYS` bits: debounced level, 1 = pressed.
- `press_pulse_o` output, `N_KEYS` bits: 1-cycle pulse on each accepted press.
- `release_pulse_o` output, `N_KEYS` bits: 1-cycle pulse on each accepted release.

## Operation

Per channel:
- **Synchroniser:** two flops, reset to 1 (released). The sampled value is `s = ~sync2` (1 = pressed).
- **FSM states:** RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
- **RELEASED:**
  - `s=1` → CONFIRM_PRESS, `cnt←0`.
  - Otherwise stay.
- **CONFIRM_PRESS:**
  - `s=0` → RELEASED, `cnt←0`; no pulse (bounce rejected).
  - `s=1` and `cnt==STABLE_CYCLES-1` → PRESSED; `pressed_o←1`, `press_pulse_o←1`.
  - Otherwise `cnt←cnt+1`.
- **PRESSED:**
  - `s=0` → CONFIRM_RELEASE, `cnt←0`.
- **CONFIRM_RELEASE:** mirror of CONFIRM_PRESS.
  - `s=1` → PRESSED, no pulse.
  - Stable for `STABLE_CYCLES` cycles → RELEASED; `pressed_o←0`, `release_pulse_o←1`.

Counter and output rules:
- `cnt` never exceeds `STABLE_CYCLES-1` and never wraps.
- `pressed_o` is a registered copy of the FSM state: 1 in PRESSED and CONFIRM_RELEASE, 0 otherwise.
- Pulses are registered and deassert on the following edge unconditionally, so each pulse lasts exactly one cycle.
- A press pulse and a release pulse never occur in the same cycle on the same channel.

Reset and channel behaviour:
- **Reset values:** `sync1`/`sync2`=1, state RELEASED, `cnt`=0, `pressed_o`=0, `press_pulse_o`=0, `release_pulse_o`=0.
- **Reset mid-operation:** asserting `reset_n` forces all outputs to 0 immediately (asynchronously), aborts any confirmation and emits no pulse. If the key is still held when reset is released, a full confirmation runs and a press pulse follows.
- **Channel independence:** channels share no state. Simultaneous events on several keys produce pulses in the same cycle.

## Timing

- Let edge k be the first rising edge at which `sync1` captures a new raw level.
  - `sync2` updates at edge k+1.
  - The FSM enters CONFIRM at edge k+2.
  - `pressed_o` and the pulse update at edge k+2+`STABLE_CYCLES`.
- **Latency:** `STABLE_CYCLES`+2 cycles from capture to output, identical for press and release.
- **Minimum accepted pulse width** on `key_n_i`: `STABLE_CYCLES`+1 cycles of stable level.
- **Outputs:** all outputs are flop outputs with no combinational path from `key_n_i`.
- **Bounce handling:** any opposite sample during CONFIRM restarts the full window from the next acceptance.

## Structure

- **Package `key_debouncer_pkg`:**
  - `typedef enum logic [1:0] key_state_t` with RELEASED=0, CONFIRM_PRESS=1, PRESSED=2, CONFIRM_RELEASE=3.
  - `localparam DEFAULT_STABLE_CYCLES = 1_000_000`.
- **Sub-module `key_debounce_channel`:** one synchroniser, FSM and counter per key, with scalar ports.
- **Top `key_debouncer`:** a generate loop of `N_KEYS` `key_debounce_channel` instances, no other logic.
- **Integration:** in `Pratica02`, instantiate with `N_KEYS=2` and `key_n_i=KEY`. `press_pulse_o[0]` gates the counter increment.

## Test plan

All scenarios use `STABLE_CYCLES=4` and `N_KEYS=2`.

1. **Reset:** `reset_n=0` with `key_n_i=2'b00` → all outputs 0 while in reset. After release, with `key_n_i` held at 00, `press_pulse_o=2'b11` for one cycle 6 edges after the first capture, then `pressed_o=2'b11`.
2. **Clean press/release:** key0 goes 1→0 and is held 20 cycles, then returns to 1.
   - `press_pulse_o[0]` is high exactly one cycle at k+6; `pressed_o[0]=1` from k+6.
   - `release_pulse_o[0]` is high one cycle 6 edges after the release capture.
   - Channel 1 stays 0 throughout.
3. **Press bounce:** key0 sequence low 3 cycles, high 1 cycle, then low held → exactly one `press_pulse_o[0]`, 6 edges after capture of the final falling edge.
4. **Release glitch:** while pressed, key0 goes high 3 cycles then low → no `release_pulse_o[0]`, and `pressed_o[0]` stays 1 throughout.
5. **Simultaneous keys:** both keys fall on the same cycle → `press_pulse_o=2'b11` on the same single cycle.
6. **Reset mid-confirm:** pull `reset_n` low while key0 is in CONFIRM_PRESS at `cnt=2` → outputs are 0 immediately and no pulse occurs. After reset release with key0 still held, one press pulse at full latency (6 edges after first capture).

Source files
------------

// File: rtl/key_debouncer_pkg.sv
// Shared types and defaults for the pushbutton debouncer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package key_debouncer_pkg;

    // Per-key debounce FSM encoding; the two CONFIRM states hold the old level
    // while the stability window is being counted.
    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } key_state_t;

    // 20 ms at 50 MHz.
    localparam int DEFAULT_STABLE_CYCLES = 1_000_000;

    // Debounced level implied by a state: the reported level only changes once
    // a confirmation window completes, so CONFIRM_RELEASE still reads pressed.
    function automatic logic state_level(input key_state_t st);
        return (st == PRESSED) || (st == CONFIRM_RELEASE);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-flop synchroniser, debounce FSM with stability counter, registered level/pulses.
// Latency: STABLE_CYCLES+2 clocks from first capture of a new raw level to the outputs.
// Backpressure: none; free-running, pulses are one clock wide and cannot be stalled.
module key_debounce_channel
    import key_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n_i,
    output logic pressed_o,
    output logic press_pulse_o,
    output logic release_pulse_o
);

    localparam int                   CNT_WIDTH = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 sync1;
    logic                 sync2;
    logic                 sample;       // 1 = key pressed, after synchronisation
    key_state_t           state_q;
    key_state_t           state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 window_done;
    logic                 pressed_d;
    logic                 press_pulse_d;
    logic                 release_pulse_d;

    // Two-flop synchroniser; resets to the released (high) raw level so no
    // spurious press is seen coming out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n_i;
            sync2 <= sync1;
        end
    end

    assign sample      = ~sync2;
    assign window_done = (cnt_q == CNT_LAST);

    // FSM state and stability counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: any opposite sample during a confirmation falls back to
    // the old level with a cleared counter, so the full window restarts.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            RELEASED: begin
                if (sample) begin
                    state_d = CONFIRM_PRESS;
                end
            end
            CONFIRM_PRESS: begin
                if (!sample) begin
                    state_d = RELEASED;
                end else if (window_done) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!sample) begin
                    state_d = CONFIRM_RELEASE;
                end
            end
            CONFIRM_RELEASE: begin
                if (sample) begin
                    state_d = PRESSED;
                end else if (window_done) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    // Output decode: pulses fire only on the accepting transition, the level
    // follows the state being entered so it lines up with the pulse.
    always_comb begin
        press_pulse_d   = (state_q == CONFIRM_PRESS)   &&  sample && window_done;
        release_pulse_d = (state_q == CONFIRM_RELEASE) && !sample && window_done;
        pressed_d       = state_level(state_d);
    end

    // Registered outputs keep key_n_i off any combinational path to the ports;
    // pulses are recomputed every clock so they drop after one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pressed_o       <= 1'b0;
            press_pulse_o   <= 1'b0;
            release_pulse_o <= 1'b0;
        end else begin
            pressed_o       <= pressed_d;
            press_pulse_o   <= press_pulse_d;
            release_pulse_o <= release_pulse_d;
        end
    end

    // Press and release are mutually exclusive on one channel.
    a_pulse_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(press_pulse_o && release_pulse_o));

    // The stability counter stays inside its window.
    a_cnt_bounded: assert property (@(posedge clk) disable iff (!reset_n)
        cnt_q <= CNT_LAST);

endmodule

// File: rtl/key_debouncer.sv
// Debounces N_KEYS active-low pushbuttons into active-high levels and press/release pulses.
// Latency: STABLE_CYCLES+2 clocks from first capture of a raw edge to the outputs.
// Backpressure: none; each channel runs independently every clock.
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int N_KEYS        = 2,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_n_i,
    output logic [N_KEYS-1:0] pressed_o,
    output logic [N_KEYS-1:0] press_pulse_o,
    output logic [N_KEYS-1:0] release_pulse_o
);

    // One fully independent debounce channel per key; channels share nothing.
    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_chan (
            .clk             (clk),
            .reset_n         (reset_n),
            .key_n_i         (key_n_i[i]),
            .pressed_o       (pressed_o[i]),
            .press_pulse_o   (press_pulse_o[i]),
            .release_pulse_o (release_pulse_o[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed stimulus for key_debouncer with STABLE_CYCLES=4, N_KEYS=2.
// Expected pulse events are queued by the stimulus; a monitor pops them on every pulse.
// Inputs change 1 time unit after a rising edge e; the pulse edge is then e+1+6.
module tb_key_debouncer;

    localparam int N_KEYS = 2;
    localparam int SC     = 4;
    localparam int LAT    = SC + 3;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic [N_KEYS-1:0] key_n_i = 2'b11;
    logic [N_KEYS-1:0] pressed_o;
    logic [N_KEYS-1:0] press_pulse_o;
    logic [N_KEYS-1:0] release_pulse_o;

    key_debouncer #(
        .N_KEYS        (N_KEYS),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .key_n_i         (key_n_i),
        .pressed_o       (pressed_o),
        .press_pulse_o   (press_pulse_o),
        .release_pulse_o (release_pulse_o)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] lvl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (edge %0d)", name, act, req, edge_n);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the event that the change just driven must produce.
    task automatic expect_event(input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
        exp_t e;
        e.cyc   = edge_n + LAT;
        e.press = p;
        e.rel   = r;
        e.lvl   = l;
        exp_q.push_back(e);
    endtask

    // Monitor: every observed pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && ((press_pulse_o != 2'b00) || (release_pulse_o != 2'b00))) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {28'd0, press_pulse_o, release_pulse_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_edge",    edge_n,          e.cyc);
                check("press_pulse",   press_pulse_o,   e.press);
                check("release_pulse", release_pulse_o, e.rel);
                check("pressed_level", pressed_o,       e.lvl);
            end
        end
    end

    initial begin
        // 1. Reset with both keys held down.
        reset_n = 1'b0;
        key_n_i = 2'b00;
        step(3);
        check("rst_pressed",  pressed_o,       0);
        check("rst_press_p",  press_pulse_o,   0);
        check("rst_release_p", release_pulse_o, 0);
        @(negedge clk);
        reset_n = 1'b1;
        expect_event(2'b11, 2'b00, 2'b11);
        step(12);
        check("post_rst_level", pressed_o, 2'b11);
        key_n_i = 2'b11;
        expect_event(2'b00, 2'b11, 2'b00);
        step(12);
        check("both_released", pressed_o, 2'b00);

        // 2. Clean press and release on key0; key1 untouched.
        key_n_i = 2'b10;
        expect_event(2'b01, 2'b00, 2'b01);
        step(20);
        check("clean_held", pressed_o, 2'b01);
        key_n_i = 2'b11;
        expect_event(2'b00, 2'b01, 2'b00);
        step(12);
        check("clean_released", pressed_o, 2'b00);

        // 3. Press bounce: low 3, high 1, then held low.
        key_n_i = 2'b10;
        step(3);
        key_n_i = 2'b11;
        step(1);
        key_n_i = 2'b10;
        expect_event(2'b01, 2'b00, 2'b01);
        step(15);
        check("bounce_held", pressed_o, 2'b01);

        // 4. Release glitch: high 3 cycles then low again; level must hold.
        key_n_i = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("glitch_level_hi", pressed_o[0], 1'b1);
        end
        key_n_i = 2'b10;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("glitch_level_lo", pressed_o[0], 1'b1);
        end
        key_n_i = 2'b11;
        expect_event(2'b00, 2'b01, 2'b00);
        step(12);

        // 5. Both keys together.
        key_n_i = 2'b00;
        expect_event(2'b11, 2'b00, 2'b11);
        step(12);
        key_n_i = 2'b11;
        expect_event(2'b00, 2'b11, 2'b00);
        step(12);

        // 6. Reset while key0 sits in CONFIRM_PRESS at cnt=2 and key1 is pressed.
        key_n_i = 2'b01;
        expect_event(2'b10, 2'b00, 2'b10);
        step(12);
        check("key1_held", pressed_o, 2'b10);
        key_n_i = 2'b00;
        step(5);
        reset_n = 1'b0;
        #1;
        check("midrst_pressed",   pressed_o,       0);
        check("midrst_press_p",   press_pulse_o,   0);
        check("midrst_release_p", release_pulse_o, 0);
        step(3);
        check("midrst_hold_level", pressed_o, 0);
        @(negedge clk);
        reset_n = 1'b1;
        expect_event(2'b11, 2'b00, 2'b11);
        step(12);
        check("after_midrst_level", pressed_o, 2'b11);
        key_n_i = 2'b11;
        expect_event(2'b00, 2'b11, 2'b00);
        step(12);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
